// File: rtl/risc16ba_mmio_pkg.sv
// Shared constants and types for the risc16ba memory-mapped peripheral block.
package risc16ba_mmio_pkg;

  // Register addresses. The word address is formed by clearing daddr[0].
  localparam logic [15:0] MMIO_LED    = 16'h0200;
  localparam logic [15:0] MMIO_LED2   = 16'h0202;
  localparam logic [15:0] MMIO_TXDATA = 16'h0204;
  localparam logic [15:0] MMIO_STATUS = 16'h0206;
  localparam logic [15:0] MMIO_CNT_LO = 16'h0208;
  localparam logic [15:0] MMIO_CNT_HI = 16'h020A;

  // STATUS register bit positions.
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  // UART transmitter states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/risc16ba_uart_tx.sv
// 8N1 UART serializer: start bit, 8 data bits LSB first, one stop bit.
//
// Handshake: a byte is transferred on a rising edge where valid && ready.
// ready is high only in IDLE and does not depend on valid; valid must not
// depend on ready. The accepted byte is captured into the shift register
// on that same edge.
//
// txd is registered from the current state, so the line lags the state by
// one cycle; this keeps txd glitch-free and gives the push-to-start-bit
// latency of two edges when fed from the FIFO in the top level.
module risc16ba_uart_tx
  import risc16ba_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [7:0]        data,
  output logic              ready,
  output logic              busy,
  output logic              txd,
  output uart_state_t       state
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  uart_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          bit_end;

  assign bit_end = (timer_q == T_LAST);
  assign ready   = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign txd     = txd_q;
  assign state   = state_q;

  // Next-state logic: bit timer, bit index, shift register and FSM.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (state_q != IDLE) begin
      timer_d = bit_end ? '0 : timer_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d   = START;
          shift_d   = data;
          timer_d   = '0;
          bit_idx_d = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the next cycle, derived from the current state.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  // State registers; reset returns the line to idle-high and aborts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

endmodule

// File: rtl/risc16ba_mmio.sv
// risc16ba memory-mapped peripherals: LED registers, UART TX FIFO plus
// serializer, and a free-running 32-bit cycle counter with a high-half
// shadow latched on every low-half read.
module risc16ba_mmio
  import risc16ba_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] daddr,
  input  logic [15:0] ddout,
  input  logic        dwe0,
  input  logic        dwe1,
  input  logic        doe,
  output logic        hit,
  output logic [15:0] rdata,
  output logic [23:0] led,
  output logic        txd
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic [15:0] a;

  logic [7:0]  led0_q, led0_d, led1_q, led1_d, led2_q, led2_d;
  logic [7:0]  fifo_mem_q [FIFO_DEPTH];
  logic [7:0]  fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;

  logic        fifo_empty, fifo_full;
  logic        push_req, push, pop, ovf_clr;
  logic        tx_ready, tx_busy;
  uart_state_t tx_state;
  logic [15:0] status;

  assign a          = daddr & 16'hfffe;
  assign hit        = (a >= MMIO_LED) && (a <= MMIO_CNT_HI);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign push_req   = dwe1 && (a == MMIO_TXDATA);
  // Fullness is judged on the registered count, before any same-cycle pop.
  assign push       = push_req && !fifo_full;
  assign pop        = !fifo_empty && tx_ready;
  assign ovf_clr    = dwe1 && (a == MMIO_STATUS) && ddout[ST_OVF];
  assign led        = {led2_q, led1_q, led0_q};

  risc16ba_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .valid (!fifo_empty),
    .data  (fifo_mem_q[rd_ptr_q]),
    .ready (tx_ready),
    .busy  (tx_busy),
    .txd   (txd),
    .state (tx_state)
  );

  // Register-file next state: LEDs, FIFO, overflow flag, counter, shadow.
  always_comb begin
    led0_d     = led0_q;
    led1_d     = led1_q;
    led2_d     = led2_q;
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q + 32'd1;
    shadow_d   = shadow_q;

    if (a == MMIO_LED) begin
      if (dwe1) led0_d = ddout[7:0];
      if (dwe0) led1_d = ddout[15:8];
    end
    if ((a == MMIO_LED2) && dwe1) led2_d = ddout[7:0];

    if (push) begin
      fifo_mem_d[wr_ptr_q] = ddout[7:0];
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A clear wins over an overflow in the same cycle.
    if (ovf_clr)                    ovf_d = 1'b0;
    else if (push_req && fifo_full) ovf_d = 1'b1;

    if (doe && (a == MMIO_CNT_LO)) shadow_d = cnt_q[31:16];
  end

  // STATUS word assembly.
  always_comb begin
    status           = 16'h0000;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_BUSY]  = tx_busy && (tx_state != IDLE);
    status[ST_OVF]   = ovf_q;
  end

  // Combinational read mux; zero unless this block is addressed and read.
  always_comb begin
    rdata = 16'h0000;
    if (doe && hit) begin
      case (a)
        MMIO_LED:    rdata = {led1_q, led0_q};
        MMIO_LED2:   rdata = {8'h00, led2_q};
        MMIO_STATUS: rdata = status;
        MMIO_CNT_LO: rdata = cnt_q[15:0];
        MMIO_CNT_HI: rdata = shadow_q;
        default:     rdata = 16'h0000;
      endcase
    end
  end

  // Control and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      led0_q   <= '0;
      led1_q   <= '0;
      led2_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      led0_q   <= led0_d;
      led1_q   <= led1_d;
      led2_q   <= led2_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  // FIFO storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

endmodule
